// File: rtl/liteeth_sram_arbiter.sv
// liteeth_sram_arbiter
// Shares the SRAM read/write port between two read/write requesters (A, B)
// with a round-robin priority pointer, and hands the SRAM read-only port to
// requester C. Every accepted transaction returns a single-cycle response
// one cycle after acceptance; read data comes straight from the SRAM port.
// C is held off for one cycle when it targets the word being written on the
// RW port in the same cycle, so it always observes the new value.
//
// Optional build macro: LITEETH_SRAM_ARB_BOUNDS_CHECK_EN
//   defined   : requests with addr >= WORD_DEPTH are accepted but do not
//               touch the SRAM; they answer with resp_err=1 and rdata=0.
//   undefined : addresses pass through unchecked; resp_err is tied low.
module liteeth_sram_arbiter #(
   parameter int BITS       = 32,
   parameter int WORD_DEPTH = 384,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,

   // requester A (read/write)
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [BITS-1:0]       a_wdata,
   input  logic [3:0]            a_wmask,
   output logic                  a_resp_valid,
   output logic                  a_resp_err,
   output logic [BITS-1:0]       a_rdata,

   // requester B (read/write)
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [BITS-1:0]       b_wdata,
   input  logic [3:0]            b_wmask,
   output logic                  b_resp_valid,
   output logic                  b_resp_err,
   output logic [BITS-1:0]       b_rdata,

   // requester C (read only)
   input  logic                  c_valid,
   output logic                  c_ready,
   input  logic [ADDR_WIDTH-1:0] c_addr,
   output logic                  c_resp_valid,
   output logic                  c_resp_err,
   output logic [BITS-1:0]       c_rdata,

   // SRAM read/write port
   output logic                  rw0_ce_in,
   output logic                  rw0_we_in,
   output logic [ADDR_WIDTH-1:0] rw0_addr_in,
   output logic [BITS-1:0]       rw0_wd_in,
   output logic [3:0]            rw0_wmask_in,
   input  logic [BITS-1:0]       rw0_rd_out,

   // SRAM read port
   output logic                  r0_ce_in,
   output logic [ADDR_WIDTH-1:0] r0_addr_in,
   input  logic [BITS-1:0]       r0_rd_out
);

   // Index of each requester in the per-requester response vectors.
   localparam int IDX_A = 0;
   localparam int IDX_B = 1;
   localparam int IDX_C = 2;

   typedef enum logic {
      PRIO_A = 1'b0,
      PRIO_B = 1'b1
   } prio_e;

   prio_e                 prio_q, prio_d;

   logic                  grant_a, grant_b, rw_grant;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [BITS-1:0]       sel_wdata;
   logic [3:0]            sel_wmask;

   logic                  rw_oob, c_oob;
   logic                  c_hazard, c_accept;

   // One bit per requester: response pending, and response carries read data.
   logic [2:0]            resp_q, resp_d;
   logic [2:0]            rd_q, rd_d;
   logic                  resp_live;

   // A depth beyond the address space would leave the upper words unreachable;
   // nothing is built here, the block only records that relation.
   if (WORD_DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_exceeds_addr_space
   end

`ifdef LITEETH_SRAM_ARB_BOUNDS_CHECK_EN
   localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = WORD_DEPTH[ADDR_WIDTH:0];

   logic [2:0] err_q, err_d;

   // Out-of-range detection for the selected RW request and for C.
   always_comb begin
      rw_oob = rw_grant && ({1'b0, sel_addr} >= DEPTH_LIMIT);
      c_oob  = ({1'b0, c_addr} >= DEPTH_LIMIT);
   end
`else
   // Without bounds checking every address is treated as in range.
   always_comb begin
      rw_oob = 1'b0;
      c_oob  = 1'b0;
   end
`endif

   // A/B arbitration: a lone requester wins, a tie goes to the pointer, and
   // the pointer always moves to the requester that was not just served.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      prio_d  = prio_q;
      if (!sys_rst) begin
         if (a_valid && (!b_valid || prio_q == PRIO_A)) begin
            grant_a = 1'b1;
         end else if (b_valid) begin
            grant_b = 1'b1;
         end
      end
      if (grant_a) begin
         prio_d = PRIO_B;
      end else if (grant_b) begin
         prio_d = PRIO_A;
      end
   end

   // Priority pointer register; reset hands the first tie to A.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         prio_q <= PRIO_A;
      end else begin
         prio_q <= prio_d;
      end
   end

   // Payload of the granted requester; all zero while nobody is granted.
   always_comb begin
      rw_grant  = grant_a | grant_b;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wmask = 4'h0;
      if (grant_a) begin
         sel_we    = a_we;
         sel_addr  = a_addr;
         sel_wdata = a_wdata;
         sel_wmask = a_wmask;
      end else if (grant_b) begin
         sel_we    = b_we;
         sel_addr  = b_addr;
         sel_wdata = b_wdata;
         sel_wmask = b_wmask;
      end
   end

   // RW port drive: an out-of-range request is accepted but never reaches the SRAM.
   always_comb begin
      rw0_ce_in    = rw_grant & ~rw_oob;
      rw0_we_in    = rw_grant & ~rw_oob & sel_we;
      rw0_addr_in  = sel_addr;
      rw0_wd_in    = sel_wdata;
      rw0_wmask_in = sel_wmask;
   end

   // C acceptance: stall one cycle when it reads the word being written now,
   // so the retry sees the freshly written data.
   always_comb begin
      c_hazard   = c_valid & rw_grant & sel_we & (c_addr == sel_addr);
      c_accept   = ~sys_rst & c_valid & ~c_hazard;
      c_ready    = c_accept;
      r0_ce_in   = c_accept & ~c_oob;
      r0_addr_in = c_addr;
      a_ready    = grant_a;
      b_ready    = grant_b;
   end

   // Next-cycle response bookkeeping for every accepted transaction.
   always_comb begin
      resp_d        = 3'b000;
      rd_d          = 3'b000;
      resp_d[IDX_A] = grant_a;
      resp_d[IDX_B] = grant_b;
      resp_d[IDX_C] = c_accept;
      rd_d[IDX_A]   = grant_a & ~a_we & ~rw_oob;
      rd_d[IDX_B]   = grant_b & ~b_we & ~rw_oob;
      rd_d[IDX_C]   = c_accept & ~c_oob;
`ifdef LITEETH_SRAM_ARB_BOUNDS_CHECK_EN
      err_d         = 3'b000;
      err_d[IDX_A]  = grant_a & rw_oob;
      err_d[IDX_B]  = grant_b & rw_oob;
      err_d[IDX_C]  = c_accept & c_oob;
`endif
   end

   // Response pipeline register; reset drops anything in flight.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         resp_q <= 3'b000;
         rd_q   <= 3'b000;
`ifdef LITEETH_SRAM_ARB_BOUNDS_CHECK_EN
         err_q  <= 3'b000;
`endif
      end else begin
         resp_q <= resp_d;
         rd_q   <= rd_d;
`ifdef LITEETH_SRAM_ARB_BOUNDS_CHECK_EN
         err_q  <= err_d;
`endif
      end
   end

   // Response outputs; a response due while reset is asserted is suppressed.
   always_comb begin
      resp_live    = ~sys_rst;
      a_resp_valid = resp_live & resp_q[IDX_A];
      b_resp_valid = resp_live & resp_q[IDX_B];
      c_resp_valid = resp_live & resp_q[IDX_C];
      a_rdata      = (resp_live & resp_q[IDX_A] & rd_q[IDX_A]) ? rw0_rd_out : '0;
      b_rdata      = (resp_live & resp_q[IDX_B] & rd_q[IDX_B]) ? rw0_rd_out : '0;
      c_rdata      = (resp_live & resp_q[IDX_C] & rd_q[IDX_C]) ? r0_rd_out  : '0;
`ifdef LITEETH_SRAM_ARB_BOUNDS_CHECK_EN
      a_resp_err   = resp_live & resp_q[IDX_A] & err_q[IDX_A];
      b_resp_err   = resp_live & resp_q[IDX_B] & err_q[IDX_B];
      c_resp_err   = resp_live & resp_q[IDX_C] & err_q[IDX_C];
`else
      a_resp_err   = 1'b0;
      b_resp_err   = 1'b0;
      c_resp_err   = 1'b0;
`endif
   end

endmodule

// File: tb/tb_liteeth_sram_arbiter.sv
// Testbench for liteeth_sram_arbiter: a behavioural SRAM sits on both ports,
// and a transaction-level reference model (shadow memory + round-robin rule)
// predicts grants, SRAM drive and responses for directed and random traffic.
module tb_liteeth_sram_arbiter;

   localparam int BITS  = 32;
   localparam int DEPTH = 384;
   localparam int AW    = 9;

   logic            sys_clk = 1'b0;
   logic            sys_rst;
   logic            a_valid, a_ready, a_we, a_resp_valid, a_resp_err;
   logic [AW-1:0]   a_addr;
   logic [BITS-1:0] a_wdata, a_rdata;
   logic [3:0]      a_wmask;
   logic            b_valid, b_ready, b_we, b_resp_valid, b_resp_err;
   logic [AW-1:0]   b_addr;
   logic [BITS-1:0] b_wdata, b_rdata;
   logic [3:0]      b_wmask;
   logic            c_valid, c_ready, c_resp_valid, c_resp_err;
   logic [AW-1:0]   c_addr;
   logic [BITS-1:0] c_rdata;
   logic            rw0_ce_in, rw0_we_in, r0_ce_in;
   logic [AW-1:0]   rw0_addr_in, r0_addr_in;
   logic [BITS-1:0] rw0_wd_in, rw0_rd_out, r0_rd_out;
   logic [3:0]      rw0_wmask_in;

   always #5 sys_clk = ~sys_clk;

   liteeth_sram_arbiter #(.BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_wmask(a_wmask), .a_resp_valid(a_resp_valid),
      .a_resp_err(a_resp_err), .a_rdata(a_rdata),
      .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_wmask(b_wmask), .b_resp_valid(b_resp_valid),
      .b_resp_err(b_resp_err), .b_rdata(b_rdata),
      .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr),
      .c_resp_valid(c_resp_valid), .c_resp_err(c_resp_err), .c_rdata(c_rdata),
      .rw0_ce_in(rw0_ce_in), .rw0_we_in(rw0_we_in), .rw0_addr_in(rw0_addr_in),
      .rw0_wd_in(rw0_wd_in), .rw0_wmask_in(rw0_wmask_in), .rw0_rd_out(rw0_rd_out),
      .r0_ce_in(r0_ce_in), .r0_addr_in(r0_addr_in), .r0_rd_out(r0_rd_out)
   );

   // Behavioural SRAM: byte-masked writes, registered reads on both ports.
   logic [BITS-1:0] mem [0:511];
   always @(posedge sys_clk) begin
      if (rw0_ce_in) begin
         if (rw0_we_in) begin
            for (int k = 0; k < 4; k++)
               if (rw0_wmask_in[k]) mem[rw0_addr_in][k*8 +: 8] <= rw0_wd_in[k*8 +: 8];
         end else begin
            rw0_rd_out <= mem[rw0_addr_in];
         end
      end
      if (r0_ce_in) r0_rd_out <= mem[r0_addr_in];
   end

   // Reference model state
   logic [BITS-1:0] ref_mem [0:511];
   int              prio;             // 0 = A next on a tie, 1 = B
   logic            pa_v, pa_e, pb_v, pb_e, pc_v, pc_e;
   logic [BITS-1:0] pa_d, pb_d, pc_d;
   logic            acc_a, acc_b, acc_c, last_a_ready, last_c_ready;
   logic [3:0]      seq;
   string           tag;
   int              n_asserts = 0;
   int              n_fail    = 0;

   function automatic logic oob(input logic [AW-1:0] addr);
`ifdef LITEETH_SRAM_ARB_BOUNDS_CHECK_EN
      return int'(addr) >= DEPTH;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic merge(input logic [AW-1:0] addr, input logic [BITS-1:0] d, input logic [3:0] m);
      for (int k = 0; k < 4; k++)
         if (m[k]) ref_mem[addr][k*8 +: 8] = d[k*8 +: 8];
   endtask

   // One clock cycle: inputs are already applied; check at negedge, then advance.
   task automatic step();
      logic ga, gb, gc, wr, er, rwce;
      logic [AW-1:0] waddr;
      @(negedge sys_clk);
      er = !sys_rst;
      chk({tag, " a_resp_valid"}, a_resp_valid, pa_v & er);
      chk({tag, " a_rdata"},      a_rdata,      (pa_v & er) ? pa_d : 32'h0);
      chk({tag, " a_resp_err"},   a_resp_err,   pa_v & er & pa_e);
      chk({tag, " b_resp_valid"}, b_resp_valid, pb_v & er);
      chk({tag, " b_rdata"},      b_rdata,      (pb_v & er) ? pb_d : 32'h0);
      chk({tag, " b_resp_err"},   b_resp_err,   pb_v & er & pb_e);
      chk({tag, " c_resp_valid"}, c_resp_valid, pc_v & er);
      chk({tag, " c_rdata"},      c_rdata,      (pc_v & er) ? pc_d : 32'h0);
      chk({tag, " c_resp_err"},   c_resp_err,   pc_v & er & pc_e);

      ga    = er && a_valid && (!b_valid || prio == 0);
      gb    = er && b_valid && (!a_valid || prio == 1);
      wr    = (ga && a_we) || (gb && b_we);
      waddr = ga ? a_addr : b_addr;
      gc    = er && c_valid && !(wr && c_addr == waddr);
      rwce  = (ga && !oob(a_addr)) || (gb && !oob(b_addr));

      chk({tag, " a_ready"},   a_ready,   ga);
      chk({tag, " b_ready"},   b_ready,   gb);
      chk({tag, " c_ready"},   c_ready,   gc);
      chk({tag, " rw0_ce_in"}, rw0_ce_in, rwce);
      chk({tag, " rw0_we_in"}, rw0_we_in, rwce && wr);
      chk({tag, " r0_ce_in"},  r0_ce_in,  gc && !oob(c_addr));
      if (rwce) chk({tag, " rw0_addr_in"}, rw0_addr_in, waddr);
      if (rwce && wr) begin
         chk({tag, " rw0_wd_in"},    rw0_wd_in,    ga ? a_wdata : b_wdata);
         chk({tag, " rw0_wmask_in"}, rw0_wmask_in, ga ? a_wmask : b_wmask);
      end
      if (gc) chk({tag, " r0_addr_in"}, r0_addr_in, c_addr);
      last_a_ready = a_ready;
      last_c_ready = c_ready;

      pa_v = ga; pa_e = ga && oob(a_addr);
      pa_d = (ga && !a_we && !oob(a_addr)) ? ref_mem[a_addr] : 32'h0;
      pb_v = gb; pb_e = gb && oob(b_addr);
      pb_d = (gb && !b_we && !oob(b_addr)) ? ref_mem[b_addr] : 32'h0;
      pc_v = gc; pc_e = gc && oob(c_addr);
      pc_d = (gc && !oob(c_addr)) ? ref_mem[c_addr] : 32'h0;
      if (ga && a_we && !oob(a_addr)) merge(a_addr, a_wdata, a_wmask);
      if (gb && b_we && !oob(b_addr)) merge(b_addr, b_wdata, b_wmask);
      if (!er) prio = 0; else if (ga) prio = 1; else if (gb) prio = 0;
      acc_a = ga; acc_b = gb; acc_c = gc;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic idle();
      a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
   endtask

   task automatic set_a(input logic we, input logic [AW-1:0] ad, input logic [31:0] d, input logic [3:0] m);
      a_valid = 1'b1; a_we = we; a_addr = ad; a_wdata = d; a_wmask = m;
   endtask

   task automatic set_b(input logic we, input logic [AW-1:0] ad, input logic [31:0] d, input logic [3:0] m);
      b_valid = 1'b1; b_we = we; b_addr = ad; b_wdata = d; b_wmask = m;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      return ($urandom_range(0, 31) == 0) ? AW'(400) : AW'($urandom_range(0, 15));
   endfunction

   initial begin
      for (int i = 0; i < 512; i++) ref_mem[i] = '0;
      prio = 0;
      pa_v = 0; pa_e = 0; pa_d = 0; pb_v = 0; pb_e = 0; pb_d = 0;
      pc_v = 0; pc_e = 0; pc_d = 0;
      acc_a = 0; acc_b = 0; acc_c = 0; last_a_ready = 0; last_c_ready = 0;
      seq = 4'h0;
      sys_rst = 1'b1;
      set_a(1'b0, 9'd1, 32'h0, 4'hF);
      set_b(1'b0, 9'd2, 32'h0, 4'hF);
      c_valid = 1'b1; c_addr = 9'd3;

      // Reset state: requests present but nothing accepted or driven.
      tag = "reset";
      step();
      step();
      sys_rst = 1'b0;

      // Both A and B valid straight after reset: grants alternate A,B,A,B.
      tag = "rr";
      c_valid = 1'b0;
      set_a(1'b1, 9'd20, 32'h0A0A0A0A, 4'hF);
      set_b(1'b1, 9'd21, 32'h0B0B0B0B, 4'hF);
      for (int i = 0; i < 4; i++) begin
         step();
         seq = {seq[2:0], last_a_ready};
      end
      chk("req035 grant sequence", {28'h0, seq}, 32'h0000000A);

      // Preload the words used by the random phase.
      tag = "preload";
      idle();
      for (int i = 0; i < 16; i++) begin
         set_a(1'b1, AW'(i), $urandom, 4'hF);
         step();
      end
      set_a(1'b1, 9'd7, 32'h11223344, 4'hF);
      step();

      // Full-word write then read back.
      tag = "req034";
      set_a(1'b1, 9'd5, 32'hDEADBEEF, 4'hF);
      step();
      set_a(1'b0, 9'd5, 32'h0, 4'h0);
      step();
      chk("req034 a_rdata", a_rdata, 32'hDEADBEEF);
      chk("req034 a_resp_valid", a_resp_valid, 1'b1);

      // Partial byte-masked write.
      tag = "req036";
      set_a(1'b1, 9'd7, 32'hAABBCCDD, 4'h5);
      step();
      set_a(1'b0, 9'd7, 32'h0, 4'h0);
      step();
      chk("req036 a_rdata", a_rdata, 32'h11BB33DD);

      // Read/write hazard between C and A on the same word.
      tag = "req037";
      set_a(1'b1, 9'd10, 32'hCAFEF00D, 4'hF);
      c_valid = 1'b1; c_addr = 9'd10;
      step();
      chk("req037 c_ready stalled", last_c_ready, 1'b0);
      a_valid = 1'b0;
      step();
      chk("req037 c_ready retry", last_c_ready, 1'b1);
      c_valid = 1'b0;
      chk("req037 c_rdata", c_rdata, 32'hCAFEF00D);
      step();

      // Out-of-range address handling.
      tag = "req038";
      set_b(1'b1, 9'd400, 32'h5A5A1234, 4'hF);
      step();
      set_b(1'b0, 9'd400, 32'h0, 4'h0);
      step();
`ifdef LITEETH_SRAM_ARB_BOUNDS_CHECK_EN
      chk("req038 b_resp_err", b_resp_err, 1'b1);
      chk("req038 b_rdata", b_rdata, 32'h0);
`else
      chk("req038 b_resp_err", b_resp_err, 1'b0);
      chk("req038 b_rdata", b_rdata, 32'h5A5A1234);
`endif
      idle();
      step();

      // Reset right after an accepted read: no response, pointer back to A.
      tag = "req039";
      set_a(1'b0, 9'd5, 32'h0, 4'h0);
      step();
      a_valid = 1'b0;
      sys_rst = 1'b1;
      step();
      chk("req039 no a_resp_valid", a_resp_valid, 1'b0);
      sys_rst = 1'b0;
      set_a(1'b0, 9'd5, 32'h0, 4'h0);
      set_b(1'b0, 9'd3, 32'h0, 4'h0);
      step();
      chk("req039 a wins after reset", last_a_ready, 1'b1);
      idle();
      step();

      // Random traffic; a request is held until it is accepted.
      tag = "rand";
      for (int n = 0; n < 400; n++) begin
         if (!a_valid || acc_a) begin
            a_valid = ($urandom_range(0, 3) != 0); a_we = 1'($urandom_range(0, 1));
            a_addr = rnd_addr(); a_wdata = $urandom; a_wmask = 4'($urandom_range(0, 15));
         end
         if (!b_valid || acc_b) begin
            b_valid = ($urandom_range(0, 3) != 0); b_we = 1'($urandom_range(0, 1));
            b_addr = rnd_addr(); b_wdata = $urandom; b_wmask = 4'($urandom_range(0, 15));
         end
         if (!c_valid || acc_c) begin
            c_valid = ($urandom_range(0, 2) != 0); c_addr = rnd_addr();
         end
         sys_rst = ($urandom_range(0, 49) == 0);
         step();
      end
      sys_rst = 1'b0;
      idle();
      tag = "drain";
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
